// File: rtl/motor_seq_pkg.sv
// Shared definitions for the motor sequencer.
// Contents:
//   state_t    - 3-bit sequencer state encoding, which is visible on state_o
//   TRAP_MAX   - upper clamp for the trapezoid percent command
//   DEF_*      - default parameter values for motor_sequencer
//   TIMER_W    - width of the tick and state down-counters
//   clamp_trap - saturates a requested trapezoid percent at TRAP_MAX
package motor_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DECEL = 3'd4,
        ST_DWELL = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    localparam logic [7:0]  TRAP_MAX         = 8'd50;

    localparam int          DEF_RAMP_DIV     = 1000;
    localparam logic [15:0] DEF_SPEED_STEP   = 16'd64;
    localparam logic [15:0] DEF_START_SPEED  = 16'd512;
    localparam int          DEF_ALIGN_CYCLES = 50000;
    localparam logic [15:0] DEF_ALIGN_TORQUE = 16'h2000;
    localparam int          DEF_DWELL_CYCLES = 20000;

    localparam int          TIMER_W          = 32;

    function automatic logic [7:0] clamp_trap(input logic [7:0] trap);
        if (trap > TRAP_MAX) begin
            return TRAP_MAX;
        end else begin
            return trap;
        end
    endfunction

endpackage

// File: rtl/motor_seq_timer.sv
// Loadable down-counter with a terminal-count indication.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   load        - loads 'period' this edge (takes precedence over counting)
//   auto_reload - when set, the counter reloads 'period' after terminal count
//   period      - load / reload value; must be >= 1
//   tc          - high during the cycle in which the count equals 1, i.e. the
//                 last cycle of a period. With auto_reload it repeats every
//                 'period' clocks; without it the counter parks at 0.
module motor_seq_timer
    import motor_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               auto_reload,
    input  logic [TIMER_W-1:0] period,
    output logic               tc
);

    logic [TIMER_W-1:0] count_r;

    // Down-counter: load has priority, then periodic reload, then decrement to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (load) begin
            count_r <= period;
        end else if (tc && auto_reload) begin
            count_r <= period;
        end else if (count_r != {TIMER_W{1'b0}}) begin
            count_r <= count_r - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == {{(TIMER_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/motor_sequencer.sv
// Run-time sequencer for the 6-step trapezoidal commutation block.
// Drives the commutation speed/torque/trap/direction commands through rotor
// alignment, linear ramps, safe reversal via zero speed plus dwell, controlled
// stop and latched fault shutdown.
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   enable                   - run request (level)
//   target_speed/torque/trap - host targets
//   target_dir               - 0 forward, 1 reverse
//   fault / fault_clr        - external fault level / one-cycle clear pulse
//   speed_cmd, torque_cmd, trap_cmd, dir_cmd - registered commutation commands
//   at_speed, busy, fault_latched, state_o   - registered status
module motor_sequencer
    import motor_seq_pkg::*;
#(
    parameter int          RAMP_DIV     = DEF_RAMP_DIV,
    parameter logic [15:0] SPEED_STEP   = DEF_SPEED_STEP,
    parameter logic [15:0] START_SPEED  = DEF_START_SPEED,
    parameter int          ALIGN_CYCLES = DEF_ALIGN_CYCLES,
    parameter logic [15:0] ALIGN_TORQUE = DEF_ALIGN_TORQUE,
    parameter int          DWELL_CYCLES = DEF_DWELL_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] target_speed,
    input  logic [15:0] target_torque,
    input  logic [7:0]  target_trap,
    input  logic        target_dir,
    input  logic        fault,
    input  logic        fault_clr,
    output logic [15:0] speed_cmd,
    output logic [15:0] torque_cmd,
    output logic [7:0]  trap_cmd,
    output logic        dir_cmd,
    output logic        at_speed,
    output logic        busy,
    output logic        fault_latched,
    output logic [2:0]  state_o
);

    localparam logic [TIMER_W-1:0] RAMP_LOAD  = TIMER_W'(RAMP_DIV);
    localparam logic [TIMER_W-1:0] ALIGN_LOAD = TIMER_W'(ALIGN_CYCLES);
    localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL_CYCLES);

    state_t             state_r;
    state_t             state_next_s;
    logic [15:0]        speed_next_s;
    logic [15:0]        torque_next_s;
    logic               dir_next_s;

    logic               entry_s;
    logic               tick_s;
    logic               state_tc_s;
    logic [TIMER_W-1:0] state_period_s;

    logic [15:0]        ramp_speed_s;
    logic [15:0]        decel_speed_s;
    logic [15:0]        first_speed_s;
    logic [16:0]        speed_up_s;
    logic [16:0]        target_up_s;

    // Timers restart on the edge that enters a new state, so the first
    // terminal count lands exactly 'period' clocks after entry.
    assign entry_s = (state_next_s != state_r);

    // Only ALIGN and DWELL use the state timer; pick their duration on entry.
    always_comb begin
        if (state_next_s == ST_ALIGN) begin
            state_period_s = ALIGN_LOAD;
        end else begin
            state_period_s = DWELL_LOAD;
        end
    end

    motor_seq_timer u_tick (
        .clk         (clk),
        .rst         (rst),
        .load        (entry_s),
        .auto_reload (1'b1),
        .period      (RAMP_LOAD),
        .tc          (tick_s)
    );

    motor_seq_timer u_state_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (entry_s),
        .auto_reload (1'b0),
        .period      (state_period_s),
        .tc          (state_tc_s)
    );

    // Widened to 17 bits so steps near 16'hFFFF saturate instead of wrapping.
    assign speed_up_s  = {1'b0, speed_cmd}    + {1'b0, SPEED_STEP};
    assign target_up_s = {1'b0, target_speed} + {1'b0, SPEED_STEP};

    // One ramp step toward target_speed, landing exactly on it.
    always_comb begin
        if (speed_cmd < target_speed) begin
            if (speed_up_s >= {1'b0, target_speed}) begin
                ramp_speed_s = target_speed;
            end else begin
                ramp_speed_s = speed_up_s[15:0];
            end
        end else begin
            if ({1'b0, speed_cmd} > target_up_s) begin
                ramp_speed_s = speed_cmd - SPEED_STEP;
            end else begin
                ramp_speed_s = target_speed;
            end
        end
    end

    // One deceleration step, floored at zero.
    always_comb begin
        if (speed_cmd > SPEED_STEP) begin
            decel_speed_s = speed_cmd - SPEED_STEP;
        end else begin
            decel_speed_s = 16'd0;
        end
    end

    // Speed that RAMP starts from after alignment.
    always_comb begin
        if (target_speed < START_SPEED) begin
            first_speed_s = target_speed;
        end else begin
            first_speed_s = START_SPEED;
        end
    end

    // Next-state and next-command decode; fault overrides every state.
    always_comb begin
        state_next_s  = state_r;
        speed_next_s  = speed_cmd;
        torque_next_s = torque_cmd;
        dir_next_s    = dir_cmd;
        if (fault) begin
            state_next_s  = ST_FAULT;
            speed_next_s  = 16'd0;
            torque_next_s = 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    speed_next_s  = 16'd0;
                    torque_next_s = 16'd0;
                    if (enable && (target_speed != 16'd0)) begin
                        state_next_s  = ST_ALIGN;
                        dir_next_s    = target_dir;
                        speed_next_s  = 16'd1;
                        torque_next_s = ALIGN_TORQUE;
                    end else begin
                        state_next_s  = ST_IDLE;
                    end
                end
                ST_ALIGN: begin
                    if (!enable) begin
                        // Leaves speed_cmd at 1; DECEL brings it to 0.
                        state_next_s  = ST_DECEL;
                        torque_next_s = target_torque;
                    end else if (state_tc_s) begin
                        state_next_s  = ST_RAMP;
                        speed_next_s  = first_speed_s;
                        torque_next_s = target_torque;
                    end else begin
                        speed_next_s  = 16'd1;
                        torque_next_s = ALIGN_TORQUE;
                    end
                end
                ST_RAMP: begin
                    torque_next_s = target_torque;
                    if (!enable) begin
                        state_next_s = ST_DECEL;
                    end else if (speed_cmd == target_speed) begin
                        state_next_s = ST_RUN;
                    end else if (tick_s) begin
                        speed_next_s = ramp_speed_s;
                        if (ramp_speed_s == target_speed) begin
                            state_next_s = ST_RUN;
                        end else begin
                            state_next_s = ST_RAMP;
                        end
                    end else begin
                        state_next_s = ST_RAMP;
                    end
                end
                ST_RUN: begin
                    torque_next_s = target_torque;
                    if (!enable) begin
                        state_next_s = ST_DECEL;
                    end else if (target_dir != dir_cmd) begin
                        state_next_s = ST_DECEL;
                    end else if (target_speed == 16'd0) begin
                        state_next_s = ST_DECEL;
                    end else if (target_speed != speed_cmd) begin
                        state_next_s = ST_RAMP;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_DECEL: begin
                    torque_next_s = target_torque;
                    if (speed_cmd == 16'd0) begin
                        state_next_s  = ST_DWELL;
                        torque_next_s = 16'd0;
                    end else if (tick_s) begin
                        speed_next_s = decel_speed_s;
                        if (decel_speed_s == 16'd0) begin
                            state_next_s  = ST_DWELL;
                            torque_next_s = 16'd0;
                        end else begin
                            state_next_s  = ST_DECEL;
                        end
                    end else begin
                        state_next_s = ST_DECEL;
                    end
                end
                ST_DWELL: begin
                    speed_next_s  = 16'd0;
                    torque_next_s = 16'd0;
                    if (state_tc_s) begin
                        if (enable && (target_speed != 16'd0)) begin
                            state_next_s  = ST_ALIGN;
                            dir_next_s    = target_dir;
                            speed_next_s  = 16'd1;
                            torque_next_s = ALIGN_TORQUE;
                        end else begin
                            state_next_s  = ST_IDLE;
                        end
                    end else begin
                        state_next_s = ST_DWELL;
                    end
                end
                ST_FAULT: begin
                    speed_next_s  = 16'd0;
                    torque_next_s = 16'd0;
                    if (fault_clr) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_FAULT;
                    end
                end
                default: begin
                    // Unreachable encoding: shut the drive down.
                    state_next_s  = ST_FAULT;
                    speed_next_s  = 16'd0;
                    torque_next_s = 16'd0;
                end
            endcase
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            state_o       <= 3'd0;
            speed_cmd     <= 16'd0;
            torque_cmd    <= 16'd0;
            trap_cmd      <= 8'd0;
            dir_cmd       <= 1'b0;
            at_speed      <= 1'b0;
            busy          <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            state_o       <= state_next_s;
            speed_cmd     <= speed_next_s;
            torque_cmd    <= torque_next_s;
            trap_cmd      <= clamp_trap(target_trap);
            dir_cmd       <= dir_next_s;
            at_speed      <= (state_next_s == ST_RUN);
            busy          <= (state_next_s != ST_IDLE) && (state_next_s != ST_FAULT);
            fault_latched <= (state_next_s == ST_FAULT);
        end
    end

endmodule

// File: doc/motor_sequencer.md
# motor_sequencer

Run-time controller that sequences the 6-step trapezoidal commutation/PWM block by generating its speed, torque, trap_percent and direction commands. It performs rotor alignment, linear speed ramps up and down, safe direction reversal through zero speed with a dwell, controlled stop and latched fault shutdown. It sits between the host/register interface (targets, enable, fault) and the commutation block, whose command inputs it drives directly from registers.

## Interface
- RAMP_DIV, 1000: clocks per ramp tick (≥1)
- SPEED_STEP, 16'd64: speed change per ramp tick
- START_SPEED, 16'd512: first speed after alignment
- ALIGN_CYCLES, 50000: clocks spent in ALIGN
- ALIGN_TORQUE, 16'h2000: torque command during ALIGN
- DWELL_CYCLES, 20000: zero-speed clocks before re-start/reversal
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  run request (level)
- target_speed  in  16  requested speed
- target_torque  in  16  requested torque in RAMP/RUN/DECEL
- target_trap  in  8  requested trapezoid percent
- target_dir  in  1  0 = forward, 1 = reverse
- fault  in  1  external fault (level)
- fault_clr  in  1  one-cycle pulse; clears latched fault
- speed_cmd  out  16  to commutation block speed
- torque_cmd  out  16  to commutation block torque
- trap_cmd  out  8  to commutation block trap_percent
- dir_cmd  out  1  to commutation block direction
- at_speed  out  1  high in RUN only
- busy  out  1  high in every state except IDLE and FAULT
- fault_latched  out  1  high in FAULT
- state_o  out  3  current state encoding

## Operation
- States: IDLE=0, ALIGN=1, RAMP=2, RUN=3, DECEL=4, DWELL=5, FAULT=6.
- IDLE: speed_cmd=0, torque_cmd=0. enable=1 and target_speed≠0 → ALIGN; dir_cmd ← target_dir on that transition.
- ALIGN: speed_cmd=1, torque_cmd=ALIGN_TORQUE for ALIGN_CYCLES clocks → RAMP with speed_cmd ← min(START_SPEED, target_speed).
- RAMP: torque_cmd=target_torque. On each tick, speed_cmd moves toward target_speed by SPEED_STEP, saturating exactly at target (17-bit compare, no overshoot or wrap). Reaching speed_cmd==target_speed → RUN.
- RUN: hold. target_speed≠speed_cmd → RAMP. target_speed==0 or target_dir≠dir_cmd → DECEL.
- DECEL: speed_cmd decreases by SPEED_STEP per tick, floored at 0. speed_cmd==0 → DWELL, with speed_cmd=0 and torque_cmd=0.
- DWELL: speed_cmd=0, torque_cmd=0 for DWELL_CYCLES clocks. Then enable=1 and target_speed≠0 → ALIGN, reloading dir_cmd; otherwise → IDLE.
- enable=0 in ALIGN/RAMP/RUN → DECEL. In ALIGN this leaves speed_cmd=1, which decrements to 0.
- fault=1 in any state → FAULT. FAULT: speed_cmd=0, torque_cmd=0. Exit only on fault_clr=1 with fault=0 → IDLE.
- trap_cmd = registered min(target_trap, 50), updated every cycle in all states.
- Invariant: dir_cmd changes only on a cycle where speed_cmd==0 (IDLE→ALIGN or DWELL→ALIGN).
- Reset: state IDLE. All outputs 0, including dir_cmd and trap_cmd. Tick and timer counters 0.

## Timing
- All outputs are registered. An input change is visible on the outputs one clock later.
- The tick counter and the state timer restart on every state entry. The first RAMP/DECEL step occurs RAMP_DIV clocks after entry.
- ALIGN lasts exactly ALIGN_CYCLES clocks; DWELL lasts exactly DWELL_CYCLES clocks.
- Priority for simultaneous events: rst > fault > enable=0 > direction change > speed change.
- fault_clr while fault=1 is ignored. fault and fault_clr in the same cycle: remain in FAULT.
- A change to target_speed during RAMP retargets on the next tick with no state change.
- A target_dir change during RAMP is acted on after reaching RUN, which then goes to DECEL.
- rst mid-operation forces IDLE and zero outputs on the next edge.

## Structure
- Package motor_seq_pkg holds: the state enum (3-bit), the trap clamp constant 8'd50, and the default parameter values.
- Sub-module motor_seq_timer: a loadable down-counter with a terminal-count pulse. Instance one is the ramp tick (reloads to RAMP_DIV). Instance two is the ALIGN/DWELL state timer.

## Test plan
Parameters for all tests: RAMP_DIV=4, SPEED_STEP=100, START_SPEED=200, ALIGN_CYCLES=8, DWELL_CYCLES=6.
- Start-up: enable=1, target_speed=450, dir=0.
  - Required: ALIGN for 8 clocks with speed_cmd=1.
  - Then speed_cmd 200→300→400→450 at 4-clock spacing.
  - Then RUN and at_speed=1.
- Reversal: in RUN at 450, set target_dir=1.
  - Required: DECEL 450→350→…→50→0 with dir_cmd still 0.
  - Then DWELL for 6 clocks and ALIGN with dir_cmd=1.
  - Then ramp back to 450.
- Retarget: in RUN at 450, set target_speed=250.
  - Required: RAMP 450→350→250, then RUN. dir_cmd unchanged.
- Fault: assert fault mid-RAMP.
  - Required: next clock speed_cmd=0, torque_cmd=0, fault_latched=1.
  - fault_clr while fault=1 → stays in FAULT.
  - Drop fault, then pulse fault_clr → IDLE.
- Stop and clamp: set enable=0 in ALIGN.
  - Required: DECEL to 0, then DWELL, then IDLE.
  - target_trap=80 → trap_cmd=50.
  - rst mid-RUN → all outputs 0 on the next clock.
